// File: rtl/csa_cpa_resolve_if.sv
// Handshake bundle for csa_cpa_resolve: carry-save pair in, resolved binary result out.
// Carries out_sat only when CSA_CPA_SAT_EN is defined.
interface csa_cpa_resolve_if #(
  parameter int S_W = 17,
  parameter int C_W = 15
);
  logic           in_valid;
  logic           in_ready;
  logic [S_W-1:0] in_sum;
  logic [C_W-1:0] in_carry;
  logic           out_valid;
  logic           out_ready;
  logic [S_W:0]   out_result;
`ifdef CSA_CPA_SAT_EN
  logic           out_sat;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_sat
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_sat
  );
`else
  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/csa_cpa_resolve.sv
// Multi-cycle chunked carry-propagate adder resolving one carry-save pair per transaction.
// Optional saturation of the result to S_W bits is enabled by defining CSA_CPA_SAT_EN.
module csa_cpa_resolve #(
  parameter int S_W     = 17,
  parameter int C_W     = 15,
  parameter int CHUNK_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_cpa_resolve_if.slave     bus
);

  localparam int R_W     = S_W + 1;
  localparam int N_CHUNK = (R_W + CHUNK_W - 1) / CHUNK_W;
  // Operands and the working result are padded to whole chunks so every slice stays in range.
  localparam int P_W     = N_CHUNK * CHUNK_W;
  localparam int CI_W    = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [P_W-1:0]  op_a_q, op_a_d;
  logic [P_W-1:0]  op_b_q, op_b_d;
  logic [P_W-1:0]  res_q, res_d;
  logic [CI_W-1:0] chunk_idx_q, chunk_idx_d;
  logic            carry_q, carry_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [R_W-1:0]  out_result_q, out_result_d;
  logic            out_sat_q, out_sat_d;

  logic [CHUNK_W-1:0] a_chunk_s;
  logic [CHUNK_W-1:0] b_chunk_s;
  logic [CHUNK_W:0]   chunk_sum_s;
  logic [P_W-1:0]     res_next_s;

  // Next-state, chunk datapath and output-register logic.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_d        = res_q;
    chunk_idx_d  = chunk_idx_q;
    carry_d      = carry_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_sat_d    = out_sat_q;
    a_chunk_s    = {CHUNK_W{1'b0}};
    b_chunk_s    = {CHUNK_W{1'b0}};
    res_next_s   = res_q;

    for (int k = 0; k < N_CHUNK; k++) begin
      if (chunk_idx_q == CI_W'(k)) begin
        a_chunk_s = op_a_q[k*CHUNK_W +: CHUNK_W];
        b_chunk_s = op_b_q[k*CHUNK_W +: CHUNK_W];
      end else begin
        a_chunk_s = a_chunk_s;
      end
    end

    chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK_W{1'b0}}, carry_q};

    for (int k = 0; k < N_CHUNK; k++) begin
      if (chunk_idx_q == CI_W'(k)) begin
        res_next_s[k*CHUNK_W +: CHUNK_W] = chunk_sum_s[CHUNK_W-1:0];
      end else begin
        res_next_s = res_next_s;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_a_d      = {{(P_W-S_W){1'b0}}, bus.in_sum};
          op_b_d      = {{(P_W-C_W){1'b0}}, bus.in_carry};
          chunk_idx_d = {CI_W{1'b0}};
          carry_d     = 1'b0;
          in_ready_d  = 1'b0;
          state_d     = ADD;
        end else begin
          in_ready_d  = 1'b1;
        end
      end
      ADD: begin
        res_d   = res_next_s;
        // Final chunk carry-out lands here too; it is always zero and never consumed.
        carry_d = chunk_sum_s[CHUNK_W];
        if (chunk_idx_q == CI_W'(N_CHUNK - 1)) begin
          state_d      = HOLD;
          out_valid_d  = 1'b1;
`ifdef CSA_CPA_SAT_EN
          if (res_next_s[S_W]) begin
            out_result_d = {1'b0, {S_W{1'b1}}};
            out_sat_d    = 1'b1;
          end else begin
            out_result_d = res_next_s[R_W-1:0];
            out_sat_d    = 1'b0;
          end
`else
          out_result_d = res_next_s[R_W-1:0];
          out_sat_d    = 1'b0;
`endif
        end else begin
          chunk_idx_d = chunk_idx_q + CI_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_sat_d   = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_sat_d   = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= {P_W{1'b0}};
      op_b_q       <= {P_W{1'b0}};
      res_q        <= {P_W{1'b0}};
      chunk_idx_q  <= {CI_W{1'b0}};
      carry_q      <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= {R_W{1'b0}};
      out_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      res_q        <= res_d;
      chunk_idx_q  <= chunk_idx_d;
      carry_q      <= carry_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
`ifdef CSA_CPA_SAT_EN
  assign bus.out_sat    = out_sat_q;
`endif

endmodule

// File: tb/tb_csa_cpa_resolve.sv
// Randomized self-checking bench for csa_cpa_resolve against an arithmetic reference model.
// Honours CSA_CPA_SAT_EN the same way as the design.
module tb_csa_cpa_resolve;

  localparam int S_W     = 17;
  localparam int C_W     = 15;
  localparam int CHUNK_W = 6;
  localparam int N_CHUNK = 3;
  localparam logic [31:0] S_MAX = (32'd1 << S_W) - 32'd1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csa_cpa_resolve_if #(.S_W(S_W), .C_W(C_W)) bus ();

  csa_cpa_resolve #(.S_W(S_W), .C_W(C_W), .CHUNK_W(CHUNK_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition, clamped when saturation is built in.
  function automatic logic [31:0] ref_sum(input logic [31:0] s, input logic [31:0] c);
    logic [31:0] r;
    r = s + c;
`ifdef CSA_CPA_SAT_EN
    if (r > S_MAX) r = S_MAX;
`endif
    return r;
  endfunction

  function automatic logic [31:0] ref_sat(input logic [31:0] s, input logic [31:0] c);
`ifdef CSA_CPA_SAT_EN
    return ((s + c) > S_MAX) ? 32'd1 : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_sat(input string tag, input logic [31:0] exp);
`ifdef CSA_CPA_SAT_EN
    check_eq(tag, {31'd0, bus.out_sat}, exp);
`else
    if (exp != 32'd0) check_eq(tag, 32'd1, 32'd0);
`endif
  endtask

  // One transaction: offer, confirm latency, optional backpressure, then release.
  task automatic run_pair(input string tag, input logic [31:0] s, input logic [31:0] c,
                          input int hold, input logic [31:0] exp);
    bus.in_sum    = s[S_W-1:0];
    bus.in_carry  = c[C_W-1:0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
    bus.in_sum   = S_W'($urandom);
    bus.in_carry = C_W'($urandom);
    for (int i = 0; i < N_CHUNK; i++) begin
      check_eq({tag, "_busy_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check_eq({tag, "_busy_ready"}, {31'd0, bus.in_ready}, 32'd0);
      tick;
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = S_W'($urandom);
      bus.in_carry = C_W'($urandom);
      check_eq({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check_eq({tag, "_hold_result"}, {14'd0, bus.out_result}, exp);
      check_eq({tag, "_hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
      tick;
    end
    bus.out_ready = 1'b1;
    check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_eq({tag, "_result"}, {14'd0, bus.out_result}, exp);
    check_sat({tag, "_sat"}, ref_sat(s, c));
    tick;
    bus.in_valid = 1'b0;
    check_eq({tag, "_done_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check_eq({tag, "_done_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check_eq({tag, "_done_hold"}, {14'd0, bus.out_result}, exp);
    check_sat({tag, "_done_sat"}, 32'd0);
  endtask

  logic [31:0] s_a [8];
  logic [31:0] c_a [8];
  int acc;
  int got;
  int last_cyc;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'($urandom);
    bus.in_sum    = S_W'($urandom);
    bus.in_carry  = C_W'($urandom);
    bus.out_ready = 1'($urandom);
    tick;
    tick;
    check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_result", {14'd0, bus.out_result}, 32'd0);
    check_eq("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_sat("rst_sat", 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    tick;

    run_pair("basic", 32'h00005, 32'h000A, 0, 32'h0000F);
`ifdef CSA_CPA_SAT_EN
    run_pair("ripple", 32'h1FFFF, 32'h0001, 0, 32'h1FFFF);
    run_pair("max", 32'h1FFFF, 32'h7FFE, 0, 32'h1FFFF);
`else
    run_pair("ripple", 32'h1FFFF, 32'h0001, 0, 32'h20000);
    run_pair("max", 32'h1FFFF, 32'h7FFE, 0, 32'h27FFD);
`endif
    run_pair("bp", 32'h0ABCD, 32'h1234, 5, ref_sum(32'h0ABCD, 32'h1234));

    // Abort an operation in its second ADD cycle.
    bus.in_sum   = 17'h12345;
    bus.in_carry = 15'h0F0F;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("midrst_result", {14'd0, bus.out_result}, 32'd0);
    check_eq("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < N_CHUNK + 2; i++) begin
      check_eq("midrst_no_ghost", {31'd0, bus.out_valid}, 32'd0);
      tick;
    end
    run_pair("after_rst", 32'h00100, 32'h0100, 0, 32'h00200);

    for (int i = 0; i < 8; i++) begin
      s_a[i] = {15'd0, 17'($urandom)};
      c_a[i] = {17'd0, 15'($urandom)};
    end
    for (int i = 0; i < 4; i++) begin
      run_pair("rand", s_a[i], c_a[i], int'($urandom_range(0, 3)), ref_sum(s_a[i], c_a[i]));
    end

    // Streaming: in_valid high whenever pairs remain, out_ready held high.
    acc      = 0;
    got      = 0;
    last_cyc = -1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      if (acc < 8) begin
        bus.in_valid = 1'b1;
        bus.in_sum   = s_a[acc][S_W-1:0];
        bus.in_carry = c_a[acc][C_W-1:0];
        check_eq("stream_ready", {31'd0, bus.in_ready}, ((cyc % 5) == 0) ? 32'd1 : 32'd0);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        if (got < 8) begin
          check_eq("stream_result", {14'd0, bus.out_result}, ref_sum(s_a[got], c_a[got]));
          check_sat("stream_sat", ref_sat(s_a[got], c_a[got]));
        end
        if (last_cyc >= 0) check_eq("stream_period", cyc - last_cyc, 32'd5);
        last_cyc = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      tick;
    end
    bus.in_valid = 1'b0;
    check_eq("stream_accepted", acc, 32'd8);
    check_eq("stream_results", got, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_cpa_resolve.md
Name: csa_cpa_resolve

Overview:
- Downstream stage of the 3:2 carry-save compressor tree.
- Accepts one carry-save pair (sum vector plus carry vector) over a valid/ready handshake.
- Resolves the pair to a single binary result with a multi-cycle, chunked carry-propagate adder (CHUNK_W bits per cycle, LSB first). This keeps the ripple path short on the MAC datapath.
- Presents the result on a valid/ready output handshake to the accumulation stage.

Parameters:
- S_W, 17, width of the carry-save sum vector (the widest compressor operand).
- C_W, 15, width of the carry vector. Must satisfy C_W <= S_W.
- CHUNK_W, 6, bits resolved per ADD cycle. Must satisfy 1 <= CHUNK_W <= S_W+1.
- Derived localparam: N_CHUNK = ceil((S_W+1)/CHUNK_W), which is 3 at defaults.

Ports:
- clk  input  1  clock; all flops on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  carry-save pair valid.
- in_ready  output  1  block can accept a pair.
- in_sum  input  S_W  sum vector; bit 0 has weight 1.
- in_carry  input  C_W  carry vector; bit 0 has weight 1 (the compressor's always-zero carry LSB position); zero-extended to S_W+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  S_W+1  binary result, in_sum + in_carry.
- out_sat  output  1  saturation flag; exists only when CSA_CPA_SAT_EN is defined.

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - out_valid=0, out_result=0, out_sat=0.
  - Operand registers, chunk index and carry flop are cleared.
  - in_ready=1 once in IDLE.
  - Reset mid-ADD or mid-HOLD discards the operation; no partial result is ever presented.
- States: IDLE, ADD, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: capture in_sum, and in_carry zero-extended, into operand registers. Clear chunk index and carry-in. Go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, add chunk k of both operands plus the carry flop. Write the CHUNK_W-bit sum into result bits [k*CHUNK_W +: CHUNK_W] (the last chunk is truncated to S_W+1). Store the chunk carry-out in the carry flop.
  - After chunk N_CHUNK-1 is written, go to HOLD.
  - The final chunk carry-out is discarded; it is always 0 because the result fits in S_W+1 bits.
- HOLD:
  - out_valid=1. out_result is the full result and stays stable while out_ready=0.
  - On out_ready=1 at an edge, go to IDLE, with out_valid=0 in the next cycle.
- Latency: for acceptance at edge t, out_valid rises after edge t+N_CHUNK. At defaults, that is the 3rd edge after acceptance.
- Throughput: one pair per N_CHUNK+2 cycles with out_ready held high.
- in_ready is a pure function of state; it never depends combinationally on in_valid or out_ready.
- in_sum and in_carry are ignored outside the IDLE handshake edge.
- out_result holds its last value after out_valid falls. Consumers use it only while out_valid=1.

Optional Feature:
- Macro: CSA_CPA_SAT_EN.
- Defined:
  - out_sat port exists.
  - In the HOLD entry cycle, if result bit S_W=1, out_result is forced to {1'b0, all ones in S_W bits} and out_sat=1. Otherwise out_sat=0.
  - out_sat is held through HOLD and cleared on the transition to IDLE and on reset.
- Undefined:
  - No out_sat port.
  - out_result is the full S_W+1-bit sum, unmodified.

Test Plan:
- Reset: rst_n low with random inputs -> out_valid=0, out_result=0, in_ready=1. Release, then in_sum=17'h00005, in_carry=15'h000A, out_ready=1 -> out_valid after the 3rd edge past acceptance, out_result=18'h0000F.
- Full carry ripple across every chunk: in_sum=17'h1FFFF, in_carry=15'h0001 -> out_result=18'h20000.
- Max operands: in_sum=17'h1FFFF, in_carry=15'h7FFE -> out_result=18'h27FFD. With CSA_CPA_SAT_EN: out_result=18'h1FFFF, out_sat=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid=1, out_result stable, in_ready=0 throughout. Raise out_ready -> IDLE next cycle, in_ready=1. A pair offered during HOLD is not accepted.
- Reset mid-operation: accept 17'h12345 + 15'h0F0F, then assert rst_n=0 in the second ADD cycle -> immediate out_valid=0, out_result=0. After release, accept 17'h00100 + 15'h00100 -> 18'h00200.
- Back-to-back stream: 8 random pairs with in_valid held high and out_ready=1 -> every result equals the reference sum, one result per 5 cycles, and no pair is dropped or duplicated.
